// File: rtl/kgp_ctrl_pkg.sv
// Shared types and encodings for the KGP-RISC main control sequencer:
// FSM states, opcodes, alu_op classes, pc_src and wb_sel selects.
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Sequencing class of an instruction; decides the path after EXEC.
  typedef enum logic [2:0] {
    CL_ALU   = 3'd0,
    CL_LW    = 3'd1,
    CL_SW    = 3'd2,
    CL_BCOND = 3'd3,
    CL_B     = 3'd4,
    CL_BR    = 3'd5,
    CL_BL    = 3'd6,
    CL_ILL   = 3'd7
  } class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_COMPI = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b000100;
  localparam logic [5:0] OP_BLTZ  = 6'b000101;
  localparam logic [5:0] OP_BZ    = 6'b000110;
  localparam logic [5:0] OP_BNZ   = 6'b000111;
  localparam logic [5:0] OP_B     = 6'b001000;
  localparam logic [5:0] OP_BR    = 6'b001001;
  localparam logic [5:0] OP_BL    = 6'b001010;

  localparam logic [2:0] ALU_R     = 3'b000;
  localparam logic [2:0] ALU_MEM   = 3'b001;
  localparam logic [2:0] ALU_BLTZ  = 3'b010;
  localparam logic [2:0] ALU_BZ    = 3'b011;
  localparam logic [2:0] ALU_BNZ   = 3'b100;
  localparam logic [2:0] ALU_ADDI  = 3'b101;
  localparam logic [2:0] ALU_COMPI = 3'b110;
  localparam logic [2:0] ALU_ILL   = 3'b111;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BRT = 2'b01;
  localparam logic [1:0] PC_SRC_REG = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

endpackage

// File: rtl/kgp_opcode_decode.sv
// Combinational opcode decode into alu_op class, immediate select,
// sequencing class and legality; the FSM registers the results in DECODE.
module kgp_opcode_decode import kgp_ctrl_pkg::*; #(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode_i,
  output logic [2:0]       alu_op_o,
  output logic             alu_src_o,
  output class_e           class_o,
  output logic             legal_o
);

  always_comb begin
    alu_op_o  = ALU_ILL;
    alu_src_o = 1'b0;
    class_o   = CL_ILL;
    legal_o   = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin alu_op_o = ALU_R;     class_o = CL_ALU; end
      OP_ADDI:  begin alu_op_o = ALU_ADDI;  class_o = CL_ALU;   alu_src_o = 1'b1; end
      OP_COMPI: begin alu_op_o = ALU_COMPI; class_o = CL_ALU;   alu_src_o = 1'b1; end
      OP_LW:    begin alu_op_o = ALU_MEM;   class_o = CL_LW;    alu_src_o = 1'b1; end
      OP_SW:    begin alu_op_o = ALU_MEM;   class_o = CL_SW;    alu_src_o = 1'b1; end
      OP_BLTZ:  begin alu_op_o = ALU_BLTZ;  class_o = CL_BCOND; end
      OP_BZ:    begin alu_op_o = ALU_BZ;    class_o = CL_BCOND; end
      OP_BNZ:   begin alu_op_o = ALU_BNZ;   class_o = CL_BCOND; end
      OP_B:     begin alu_op_o = ALU_R;     class_o = CL_B;     end
      OP_BR:    begin alu_op_o = ALU_R;     class_o = CL_BR;    end
      OP_BL:    begin alu_op_o = ALU_R;     class_o = CL_BL;    end
      default:  legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/kgp_main_control.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer; memories stall it by withholding ack.
// KGP_CTRL_TRAP_EN: illegal opcodes trap instead of retiring as NOPs.
module kgp_main_control import kgp_ctrl_pkg::*; #(
  parameter int OPC_W    = 6,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  input  logic             br_cond,
  output logic [2:0]       alu_op,
  output logic [OPC_W-1:0] func,
  output logic             alu_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [2:0]       state_o
);

  state_e           state_q, state_d;
  class_e           class_q, class_d, dec_class;
  logic [2:0]       alu_op_q, alu_op_d, dec_alu_op;
  logic [OPC_W-1:0] func_q, func_d, opcode;
  logic             alu_src_q, alu_src_d, dec_alu_src, dec_legal;
  logic             trap_q, trap_d, run_q, waiting;
  logic [7:0]       wait_q, wait_d;
  logic             unused_instr_bits;

  assign opcode            = instr[31 -: OPC_W];
  assign unused_instr_bits = ^instr[31-OPC_W:OPC_W];

  kgp_opcode_decode #(.OPC_W(OPC_W)) u_dec (
    .opcode_i  (opcode),
    .alu_op_o  (dec_alu_op),
    .alu_src_o (dec_alu_src),
    .class_o   (dec_class),
    .legal_o   (dec_legal)
  );

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    alu_op_d  = alu_op_q;
    func_d    = func_q;
    alu_src_d = alu_src_q;
    trap_d    = trap_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SRC_SEQ;
    reg_we    = 1'b0;
    waiting   = 1'b0;
    case (state_q)
      // run_q keeps the request low for the cycle in which reset is released
      ST_FETCH: if (run_q) begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_DECODE: begin
        alu_op_d  = dec_alu_op;
        func_d    = (opcode == OP_RTYPE) ? instr[OPC_W-1:0] : '0;
        alu_src_d = dec_alu_src;
        class_d   = dec_class;
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
`ifdef KGP_CTRL_TRAP_EN
          state_d = ST_TRAP;
          trap_d  = 1'b1;
`else
          state_d = ST_FETCH;
`endif
        end
      end
      ST_EXEC: begin
        case (class_q)
          CL_LW, CL_SW: state_d = ST_MEM;
          CL_BCOND: begin pc_src = PC_SRC_BRT; pc_we = br_cond; state_d = ST_FETCH; end
          CL_B:     begin pc_src = PC_SRC_BRT; pc_we = 1'b1;    state_d = ST_FETCH; end
          CL_BR:    begin pc_src = PC_SRC_REG; pc_we = 1'b1;    state_d = ST_FETCH; end
          CL_BL:    begin pc_src = PC_SRC_BRT; pc_we = 1'b1;    state_d = ST_WB;    end
          default:  state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (class_q == CL_SW);
        if (dmem_ack) state_d = (class_q == CL_SW) ? ST_FETCH : ST_WB;
        else          waiting = 1'b1;
      end
      ST_WB: begin
        reg_we  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    // Any cycle that is not an unacknowledged wait restarts the count.
    wait_d = 8'd0;
    if (waiting) begin
      if (wait_q == 8'(WAIT_MAX - 1)) begin
        state_d = ST_TRAP;
        trap_d  = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      class_q   <= CL_ALU;
      alu_op_q  <= '0;
      func_q    <= '0;
      alu_src_q <= 1'b0;
      trap_q    <= 1'b0;
      run_q     <= 1'b0;
      wait_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      alu_op_q  <= alu_op_d;
      func_q    <= func_d;
      alu_src_q <= alu_src_d;
      trap_q    <= trap_d;
      run_q     <= 1'b1;
      wait_q    <= wait_d;
    end
  end

  assign alu_op  = alu_op_q;
  assign func    = func_q;
  assign alu_src = alu_src_q;
  assign trap    = trap_q;
  assign state_o = state_q;
  assign wb_sel  = (class_q == CL_LW) ? WB_MEM :
                   (class_q == CL_BL) ? WB_LINK : WB_ALU;

endmodule

// File: tb/tb_kgp_main_control.sv
// Bench for kgp_main_control: per-instruction expected cycle traces built from the
// instruction-level rules, replayed against the DUT with randomized acks and operands.
module tb_kgp_main_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, br_cond = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, alu_src, trap;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  alu_op, state_o;
  logic [5:0]  func;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] iw;
    logic        ia, da, bc;
    logic [2:0]  st;
    logic        ireq, irwe, pcwe;
    logic [1:0]  pcs;
    logic        dreq, dwe, rwe;
    logic [1:0]  wbs;
    logic        trp, dchk;
    logic [2:0]  aop;
    logic [5:0]  fn;
    logic        asrc;
  } cyc_t;

  cyc_t       tr[$];
  logic [2:0] cur_aop;
  logic [5:0] cur_fn;
  logic       cur_asrc;

  always #5 clk = ~clk;

  kgp_main_control dut (
    .clk(clk), .rst(rst), .instr(instr),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .br_cond(br_cond),
    .alu_op(alu_op), .func(func), .alu_src(alu_src), .reg_we(reg_we),
    .wb_sel(wb_sel), .trap(trap), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] spec_alu_op(input logic [5:0] opc);
    case (opc)
      6'd0:       return 3'b000;
      6'd1:       return 3'b101;
      6'd2:       return 3'b110;
      6'd3, 6'd4: return 3'b001;
      6'd5:       return 3'b010;
      6'd6:       return 3'b011;
      6'd7:       return 3'b100;
      6'd8, 6'd9, 6'd10: return 3'b000;
      default:    return 3'b111;
    endcase
  endfunction

  // One expected cycle; inputs that the current phase ignores are randomized.
  function automatic cyc_t mk(input logic [31:0] iw, input logic [2:0] st, input logic dchk);
    cyc_t c;
    c.iw = iw; c.st = st;
    c.ia = 1'($urandom_range(0, 1));
    c.da = 1'($urandom_range(0, 1));
    c.bc = 1'($urandom_range(0, 1));
    c.ireq = 1'b0; c.irwe = 1'b0; c.pcwe = 1'b0; c.pcs = 2'b00;
    c.dreq = 1'b0; c.dwe = 1'b0; c.rwe = 1'b0; c.wbs = 2'b00;
    c.trp = 1'b0; c.dchk = dchk;
    c.aop = cur_aop; c.fn = cur_fn; c.asrc = cur_asrc;
    return c;
  endfunction

  task automatic build(input logic [31:0] iw, input int fd, input int md, input logic bc);
    logic [5:0] opc;
    cyc_t       c;
    opc      = iw[31:26];
    cur_aop  = spec_alu_op(opc);
    cur_fn   = (opc == 6'd0) ? iw[5:0] : 6'd0;
    cur_asrc = (opc >= 6'd1 && opc <= 6'd4);
    for (int i = 0; i < fd; i++) begin
      c = mk(iw, 3'd0, 1'b0); c.ia = 1'b0; c.ireq = 1'b1; tr.push_back(c);
    end
    c = mk(iw, 3'd0, 1'b0); c.ia = 1'b1; c.ireq = 1'b1; c.irwe = 1'b1; c.pcwe = 1'b1;
    tr.push_back(c);
    tr.push_back(mk(iw, 3'd1, 1'b0));
    if (opc > 6'd10) begin
`ifdef KGP_CTRL_TRAP_EN
      for (int i = 0; i < 4; i++) begin
        c = mk(iw, 3'd5, 1'b0); c.trp = 1'b1; tr.push_back(c);
      end
`endif
      return;
    end
    c = mk(iw, 3'd2, 1'b1);
    case (opc)
      6'd5, 6'd6, 6'd7: begin c.bc = bc; c.pcwe = bc; c.pcs = 2'b01; end
      6'd8, 6'd10:      begin c.pcwe = 1'b1; c.pcs = 2'b01; end
      6'd9:             begin c.pcwe = 1'b1; c.pcs = 2'b10; end
      default: ;
    endcase
    tr.push_back(c);
    if (opc == 6'd3 || opc == 6'd4) begin
      for (int i = 0; i <= md; i++) begin
        c = mk(iw, 3'd3, 1'b1); c.da = (i == md); c.dreq = 1'b1; c.dwe = (opc == 6'd4);
        tr.push_back(c);
      end
    end
    if (opc inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd10}) begin
      c = mk(iw, 3'd4, 1'b1); c.rwe = 1'b1;
      c.wbs = (opc == 6'd3) ? 2'b01 : (opc == 6'd10) ? 2'b10 : 2'b00;
      tr.push_back(c);
    end
  endtask

  task automatic play(input int n);
    cyc_t c;
    for (int k = 0; k < n && tr.size() > 0; k++) begin
      c = tr.pop_front();
      instr = c.iw; imem_ack = c.ia; dmem_ack = c.da; br_cond = c.bc;
      @(negedge clk);
      chk("state_o",  32'(state_o),  32'(c.st));
      chk("imem_req", 32'(imem_req), 32'(c.ireq));
      chk("ir_we",    32'(ir_we),    32'(c.irwe));
      chk("pc_we",    32'(pc_we),    32'(c.pcwe));
      chk("dmem_req", 32'(dmem_req), 32'(c.dreq));
      chk("reg_we",   32'(reg_we),   32'(c.rwe));
      chk("trap",     32'(trap),     32'(c.trp));
      if (c.pcwe) chk("pc_src",  32'(pc_src),  32'(c.pcs));
      if (c.dreq) chk("dmem_we", 32'(dmem_we), 32'(c.dwe));
      if (c.rwe)  chk("wb_sel",  32'(wb_sel),  32'(c.wbs));
      if (c.dchk) begin
        chk("alu_op",  32'(alu_op),  32'(c.aop));
        chk("func",    32'(func),    32'(c.fn));
        chk("alu_src", 32'(alu_src), 32'(c.asrc));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; br_cond = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state",  32'(state_o),  32'd0);
    chk("rst_imem",   32'(imem_req), 32'd0);
    chk("rst_enables", 32'({ir_we, pc_we, dmem_req, dmem_we, reg_we}), 32'd0);
    chk("rst_trap",   32'(trap),     32'd0);
    chk("rst_fields", 32'({alu_op, func, pc_src, wb_sel}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run1(input logic [31:0] iw, input int fd, input int md, input logic bc);
    build(iw, fd, md, bc);
    play(1 << 20);
`ifdef KGP_CTRL_TRAP_EN
    if (iw[31:26] > 6'd10) do_reset();
`endif
  endtask

  initial begin
    logic [5:0]  opc;
    logic [31:0] iw;

    do_reset();

    run1(32'h0000_0003, 0, 0, 1'b0);            // R-type xor, zero-wait
    run1({6'd3, 26'h012_3456}, 0, 3, 1'b0);     // lw, dmem ack after 3 waits
    run1({6'd6, 26'h000_0010}, 0, 0, 1'b0);     // bz not taken
    run1({6'd6, 26'h000_0010}, 0, 0, 1'b1);     // bz taken
    for (int op = 1; op <= 10; op++)
      run1({6'(op), 20'($urandom), 6'h2a}, 1, 1, 1'b1);
    run1({6'h3f, 26'h155_5555}, 0, 0, 1'b0);    // illegal opcode
    run1(32'h0000_0021, 0, 0, 1'b0);
    run1({6'd3, 26'h000_0004}, 254, 254, 1'b0); // longest waits that still complete

    for (int n = 0; n < 60; n++) begin
      opc = 6'($urandom_range(0, 12));
      if (opc > 6'd10) opc = 6'($urandom_range(11, 63));
      iw = {opc, 20'($urandom), 6'($urandom)};
      run1(iw, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset while the fetch handshake is still outstanding.
    build({6'd3, 26'h0}, 10, 0, 1'b0);
    play(5);
    tr.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_imem",  32'(imem_req), 32'd0);
    chk("midrst_state", 32'(state_o),  32'd0);
    @(posedge clk); #1;
    do_reset();

    // Instruction fetch never acknowledged: trap after WAIT_MAX waits.
    imem_ack = 1'b0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      chk("to_wait_req",  32'(imem_req), 32'd1);
      chk("to_wait_trap", 32'(trap),     32'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("to_trap",    32'(trap),    32'd1);
      chk("to_state",   32'(state_o), 32'd5);
      chk("to_enables", 32'({imem_req, ir_we, pc_we, dmem_req, reg_we}), 32'd0);
      @(posedge clk); #1;
    end
    do_reset();
    run1(32'h0000_0005, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
